// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types and the per-lane add/subtract helper for the SPU add/sub op.
// Saturation is selected by ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN in the lane and top files.
package elixirchip_es1_spu_pkg;

   localparam int LATENCY_MAX = 4;
   localparam int LANE_MAX    = 32;

   typedef logic [LANE_MAX-1:0] lane_t;

   // Returns {carry_out, carry_into_msb, sum}; only the low `width` bits of sum are meaningful.
   function automatic logic [LANE_MAX+1:0] add_lane(input lane_t d0, input lane_t d1,
                                                    input logic c, input logic sub,
                                                    input logic [5:0] width);
      logic [LANE_MAX:0] mask, a, b, full;
      logic [5:0]        top;
      mask = ({{LANE_MAX{1'b0}}, 1'b1} << width) - {{LANE_MAX{1'b0}}, 1'b1};
      a    = {1'b0, d0} & mask;
      b    = {1'b0, (sub ? ~d1 : d1)} & mask;
      full = a + b + {{LANE_MAX{1'b0}}, c};
      top  = width - 6'd1;
      return {full[width], a[top] ^ b[top] ^ full[top], full[LANE_MAX-1:0] & mask[LANE_MAX-1:0]};
   endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_addsub_lane.sv
// One lane of the stage-0 adder, with optional signed clamp.
// ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN adds the clamp inputs and the raw sign output.
module elixirchip_es1_spu_op_addsub_lane
   import elixirchip_es1_spu_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter bit TOP_LANE  = 1'b1
) (
   input  logic [DATA_BITS-1:0] d0,
   input  logic [DATA_BITS-1:0] d1,
   input  logic                 carry_in,
   input  logic                 sub,
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
   input  logic                 sat_ovf,
   input  logic                 sat_pos,
   output logic                 sign,
`endif
   output logic [DATA_BITS-1:0] sum,
   output logic                 carry_out,
   output logic                 msb_c
);

   logic [LANE_MAX+1:0]  r;
   logic [DATA_BITS-1:0] raw;

   assign r         = add_lane(lane_t'(d0), lane_t'(d1), carry_in, sub, 6'(DATA_BITS));
   assign carry_out = r[LANE_MAX+1];
   assign msb_c     = r[LANE_MAX];
   assign raw       = r[DATA_BITS-1:0];

   generate
      if (DATA_BITS < LANE_MAX) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^r[LANE_MAX-1:DATA_BITS];
      end
   endgenerate

`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
   // Lower lanes of a chained word clamp to all-ones/all-zeros; only the top lane carries the sign.
   logic [DATA_BITS-1:0] clamp;
   always_comb begin
      clamp = sat_pos ? '1 : '0;
      if (TOP_LANE) clamp[DATA_BITS-1] = ~sat_pos;
   end
   assign sum  = sat_ovf ? clamp : raw;
   assign sign = raw[DATA_BITS-1];
`else
   localparam bit unused_top = TOP_LANE;
   assign sum = raw;
`endif

endmodule

// File: rtl/elixirchip_es1_spu_op_addsub_lanes.sv
// Multi-lane pipelined add/subtract SPU op: stage-0 adders, delay pipe, held output registers.
// ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN enables signed saturation.
module elixirchip_es1_spu_op_addsub_lanes
   import elixirchip_es1_spu_pkg::*;
#(
   parameter int             LATENCY     = 1,
   parameter int             DATA_BITS   = 8,
   parameter int             LANES       = 4,
   parameter bit             CHAIN       = 1'b0,
   parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0,
   parameter bit             CLEAR_CARRY = 1'b0,
   parameter bit             CLEAR_MSB_C = 1'b0,
   parameter                 DEVICE      = "RTL",
   parameter                 SIMULATION  = "false",
   parameter                 DEBUG       = "false"
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cke,
   input  logic                       s_sub,
   input  logic                       s_carry,
   input  logic [LANES*DATA_BITS-1:0] s_data0,
   input  logic [LANES*DATA_BITS-1:0] s_data1,
   input  logic                       s_clear,
   input  logic                       s_valid,
   output logic [LANES*DATA_BITS-1:0] m_data,
   output logic [LANES-1:0]           m_carry,
   output logic [LANES-1:0]           m_msb_c,
   output logic                       m_valid
);

   localparam int W   = LANES * DATA_BITS;
   localparam int LAT = (LATENCY < 1) ? 1 : ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
   localparam bit unused_cfg = (DEVICE == "") || (SIMULATION == "") || (DEBUG == "");

   logic [W-1:0]     sum;
   logic [LANES-1:0] co, mc;

   genvar i;
   generate
      for (i = 0; i < LANES; i++) begin : g_lane
         logic ci, co_l, mc_l;
         if (CHAIN && i > 0) begin : g_chain
            assign ci = g_lane[i-1].co_l;
         end else begin : g_own
            assign ci = s_carry;
         end
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
         logic sg_l, ovf, pos;
         // A chained word overflows only at its top lane; every lane follows that decision.
         if (CHAIN) begin : g_wide
            assign ovf = g_lane[LANES-1].co_l ^ g_lane[LANES-1].mc_l;
            assign pos = g_lane[LANES-1].sg_l;
         end else begin : g_narrow
            assign ovf = co_l ^ mc_l;
            assign pos = sg_l;
         end
`endif
         elixirchip_es1_spu_op_addsub_lane #(
            .DATA_BITS (DATA_BITS),
            .TOP_LANE  (!CHAIN || (i == LANES-1))
         ) u_lane (
            .d0        (s_data0[i*DATA_BITS +: DATA_BITS]),
            .d1        (s_data1[i*DATA_BITS +: DATA_BITS]),
            .carry_in  (ci),
            .sub       (s_sub),
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
            .sat_ovf   (ovf),
            .sat_pos   (pos),
            .sign      (sg_l),
`endif
            .sum       (sum[i*DATA_BITS +: DATA_BITS]),
            .carry_out (co_l),
            .msb_c     (mc_l)
         );
         assign co[i] = co_l;
         assign mc[i] = mc_l;
      end
   endgenerate

   logic [W-1:0]     d_data;
   logic [LANES-1:0] d_carry, d_msbc;
   logic             d_valid, d_clear;

   generate
      if (LAT > 1) begin : g_pipe
         logic [LAT-2:0][W-1:0]     p_data;
         logic [LAT-2:0][LANES-1:0] p_carry, p_msbc;
         logic [LAT-2:0]            vld_pipe, clr_pipe;
         always_ff @(posedge clk) begin
            if (reset) begin
               p_data   <= '0;
               p_carry  <= '0;
               p_msbc   <= '0;
               vld_pipe <= '0;
               clr_pipe <= '0;
            end else if (cke) begin
               p_data[0]   <= sum;
               p_carry[0]  <= co;
               p_msbc[0]   <= mc;
               vld_pipe[0] <= s_valid;
               clr_pipe[0] <= s_clear & s_valid;
               for (int k = 1; k < LAT-1; k++) begin
                  p_data[k]   <= p_data[k-1];
                  p_carry[k]  <= p_carry[k-1];
                  p_msbc[k]   <= p_msbc[k-1];
                  vld_pipe[k] <= vld_pipe[k-1];
                  clr_pipe[k] <= clr_pipe[k-1];
               end
            end
         end
         assign d_data  = p_data[LAT-2];
         assign d_carry = p_carry[LAT-2];
         assign d_msbc  = p_msbc[LAT-2];
         assign d_valid = vld_pipe[LAT-2];
         assign d_clear = clr_pipe[LAT-2];
      end else begin : g_direct
         assign d_data  = sum;
         assign d_carry = co;
         assign d_msbc  = mc;
         assign d_valid = s_valid;
         assign d_clear = s_clear & s_valid;
      end
   endgenerate

   // Output registers hold their last result between valid ops.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_data  <= '0;
         m_carry <= '0;
         m_msb_c <= '0;
         m_valid <= 1'b0;
      end else if (cke) begin
         m_valid <= d_valid;
         if (d_valid) begin
            if (d_clear) begin
               m_data  <= {LANES{CLEAR_DATA}};
               m_carry <= {LANES{CLEAR_CARRY}};
               m_msb_c <= {LANES{CLEAR_MSB_C}};
            end else begin
               m_data  <= d_data;
               m_carry <= d_carry;
               m_msb_c <= d_msbc;
            end
         end
      end
   end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_addsub_lanes.sv
// Bench: two configurations (lane-parallel LATENCY=1, chained LATENCY=3) against a behavioural model.
module tb_elixirchip_es1_spu_op_addsub_lanes;

   logic        clk = 1'b0;
   logic        reset, cke, s_sub, s_carry, s_clear, s_valid;
   logic [31:0] s_data0, s_data1;
   logic [31:0] a_data, b_data;
   logic [3:0]  a_carry, b_carry, a_msbc, b_msbc;
   logic        a_valid, b_valid;

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_addsub_lanes #(
      .LATENCY(1), .DATA_BITS(8), .LANES(4), .CHAIN(1'b0),
      .CLEAR_DATA(8'hA5), .CLEAR_CARRY(1'b1), .CLEAR_MSB_C(1'b0)
   ) dut_a (
      .clk(clk), .reset(reset), .cke(cke), .s_sub(s_sub), .s_carry(s_carry),
      .s_data0(s_data0), .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(a_data), .m_carry(a_carry), .m_msb_c(a_msbc), .m_valid(a_valid)
   );

   elixirchip_es1_spu_op_addsub_lanes #(
      .LATENCY(3), .DATA_BITS(8), .LANES(4), .CHAIN(1'b1),
      .CLEAR_DATA(8'h3C), .CLEAR_CARRY(1'b0), .CLEAR_MSB_C(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .cke(cke), .s_sub(s_sub), .s_carry(s_carry),
      .s_data0(s_data0), .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(b_data), .m_carry(b_carry), .m_msb_c(b_msbc), .m_valid(b_valid)
   );

   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { bit v; bit clr; bit [31:0] d; bit [3:0] c; bit [3:0] m; } op_t;

   function automatic op_t calc(bit chain, bit [31:0] d0, bit [31:0] d1, bit c, bit sub, bit v, bit clr);
      op_t o;
      longint unsigned a, b, cc, la, lb, s, mk, mk2;
      longint sa, sb, t;
      a = 64'(d0); b = 64'(sub ? ~d1 : d1); cc = 64'(c);
      o.v = v; o.clr = clr & v; o.d = '0; o.c = '0; o.m = '0;
      if (!chain) begin
         for (int i = 0; i < 4; i++) begin
            la = (a >> (8*i)) & 64'hFF;
            lb = (b >> (8*i)) & 64'hFF;
            s  = la + lb + cc;
            o.d[8*i +: 8] = s[7:0];
            o.c[i] = s[8];
            o.m[i] = (((la & 64'h7F) + (lb & 64'h7F) + cc) >> 7) != 0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
            sa = (la >= 128) ? longint'(la) - 256 : longint'(la);
            sb = (lb >= 128) ? longint'(lb) - 256 : longint'(lb);
            t  = sa + sb + longint'(cc);
            if (t > 127) o.d[8*i +: 8] = 8'h7F;
            else if (t < -128) o.d[8*i +: 8] = 8'h80;
`endif
         end
      end else begin
         s = a + b + cc;
         o.d = s[31:0];
         for (int i = 0; i < 4; i++) begin
            mk  = (64'd1 << (8*(i+1))) - 1;
            mk2 = (64'd1 << (8*i+7)) - 1;
            o.c[i] = (((a & mk) + (b & mk) + cc) >> (8*(i+1))) != 0;
            o.m[i] = (((a & mk2) + (b & mk2) + cc) >> (8*i+7)) != 0;
         end
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
         sa = longint'($signed(d0));
         sb = longint'($signed(sub ? ~d1 : d1));
         t  = sa + sb + longint'(cc);
         if (t > 64'sd2147483647) o.d = 32'h7FFFFFFF;
         else if (t < -64'sd2147483648) o.d = 32'h80000000;
`endif
      end
      return o;
   endfunction

   op_t       q [2][$];
   bit [31:0] ed [2];
   bit [3:0]  ec [2], em [2];
   bit        ev [2];

   always @(posedge clk) begin
      op_t o, idle;
      idle = '{v: 1'b0, clr: 1'b0, d: '0, c: '0, m: '0};
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            q[k].delete();
            for (int j = 0; j < (k ? 3 : 1) - 1; j++) q[k].push_back(idle);
            ed[k] = '0; ec[k] = '0; em[k] = '0; ev[k] = 1'b0;
         end else if (cke) begin
            q[k].push_back(calc(k == 1, s_data0, s_data1, s_carry, s_sub, s_valid, s_clear));
            o = q[k].pop_front();
            ev[k] = o.v;
            if (o.v && o.clr) begin
               ed[k] = k ? 32'h3C3C3C3C : 32'hA5A5A5A5;
               ec[k] = k ? 4'h0 : 4'hF;
               em[k] = k ? 4'hF : 4'h0;
            end else if (o.v) begin
               ed[k] = o.d; ec[k] = o.c; em[k] = o.m;
            end
         end
      end
   end

   // Every cycle after reset: both DUTs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_valid", {63'd0, a_valid}, {63'd0, ev[0]});
         chk("a_data",  {32'd0, a_data},  {32'd0, ed[0]});
         chk("a_carry", {60'd0, a_carry}, {60'd0, ec[0]});
         chk("a_msb_c", {60'd0, a_msbc},  {60'd0, em[0]});
         chk("b_valid", {63'd0, b_valid}, {63'd0, ev[1]});
         chk("b_data",  {32'd0, b_data},  {32'd0, ed[1]});
         chk("b_carry", {60'd0, b_carry}, {60'd0, ec[1]});
         chk("b_msb_c", {60'd0, b_msbc},  {60'd0, em[1]});
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input bit clr, input bit sub, input bit c,
                        input bit [31:0] d0, input bit [31:0] d1);
      s_valid = v; s_clear = clr; s_sub = sub; s_carry = c; s_data0 = d0; s_data1 = d1;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; cke = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      step(3);
      chk_en = 1'b1;
      chk("rst_a_data", {32'd0, a_data}, 64'd0);
      chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
      reset = 1'b0;
      step(1);

      // lane-parallel add, one-edge latency
      drive(1, 0, 0, 0, 32'h01FF7F10, 32'h01010101);
      step(1); drive(0, 0, 0, 0, 32'h0, 32'h0);
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
      chk("lit_add_data", {32'd0, a_data}, 64'h02007F11);
`else
      chk("lit_add_data", {32'd0, a_data}, 64'h02008011);
`endif
      chk("lit_add_carry", {60'd0, a_carry}, 64'b0100);
      chk("lit_add_msbc", {60'd0, a_msbc}, 64'b0110);
      chk("lit_add_valid", {63'd0, a_valid}, 64'd1);
      step(1);
      chk("lit_valid_drop", {63'd0, a_valid}, 64'd0);

      // chained ripple across the whole word, three-edge latency
      drive(1, 0, 0, 0, 32'h00FFFFFF, 32'h00000001);
      step(1); drive(0, 0, 0, 0, 32'h0, 32'h0);
      step(1);
      chk("lit_chain_early", {63'd0, b_valid}, 64'd0);
      step(1);
      chk("lit_chain_data", {32'd0, b_data}, 64'h01000000);
      chk("lit_chain_carry", {60'd0, b_carry}, 64'b0111);
      chk("lit_chain_valid", {63'd0, b_valid}, 64'd1);

      // subtract with not-borrow in
      drive(1, 0, 1, 1, 32'h07050705, 32'h05070507);
      step(1); drive(0, 0, 0, 0, 32'h0, 32'h0);
      chk("lit_sub_data", {32'd0, a_data}, 64'h02FE02FE);
      chk("lit_sub_carry", {60'd0, a_carry}, 64'b1010);

      // clear with valid, then clear without valid
      drive(1, 1, 0, 0, 32'h12345678, 32'h9ABCDEF0);
      step(1);
      chk("lit_clr_data", {32'd0, a_data}, 64'hA5A5A5A5);
      chk("lit_clr_carry", {60'd0, a_carry}, 64'hF);
      drive(0, 1, 0, 0, 32'h11111111, 32'h22222222);
      step(1);
      chk("lit_clr_novalid", {32'd0, a_data}, 64'hA5A5A5A5);
      chk("lit_clr_novalid_v", {63'd0, a_valid}, 64'd0);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      step(3);

      // clock-enable gaps on the three-deep pipe
      drive(1, 0, 0, 0, 32'h10203040, 32'h01010101);
      step(1); drive(0, 0, 0, 0, 32'h0, 32'h0);
      cke = 1'b0; step(1);
      chk("lit_cke_hold0", {63'd0, b_valid}, 64'd0);
      cke = 1'b1; step(1);
      chk("lit_cke_two", {63'd0, b_valid}, 64'd0);
      step(1);
      chk("lit_cke_data", {32'd0, b_data}, 64'h11213141);
      cke = 1'b0; step(1);
      chk("lit_cke_held_v", {63'd0, b_valid}, 64'd1);
      cke = 1'b1;

      // saturating (or wrapping) lanes
      drive(1, 0, 0, 0, 32'h0000807F, 32'h0000FF01);
      step(1); drive(0, 0, 0, 0, 32'h0, 32'h0);
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
      chk("lit_sat_data", {32'd0, a_data}, 64'h0000807F);
`else
      chk("lit_sat_data", {32'd0, a_data}, 64'h00007F80);
`endif

      // reset with an op in flight
      drive(1, 0, 0, 0, 32'h01020304, 32'h01010101);
      step(1); drive(0, 0, 0, 0, 32'h0, 32'h0);
      reset = 1'b1; step(1); reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("lit_rst_midpipe", {63'd0, b_valid}, 64'd0);
      end
      chk("lit_rst_data", {32'd0, b_data}, 64'd0);

      // randomized traffic, model-checked every cycle
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom),
               1'($urandom), $urandom, $urandom);
         if ($urandom_range(0, 7) == 0) s_data1 = ~s_data0;
         cke   = $urandom_range(0, 4) != 0;
         reset = $urandom_range(0, 99) == 0;
         step(1);
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
